// File: rtl/rv_imem_pkg.sv
// Shared types and constants for the instruction-memory fetch block.
package rv_imem_pkg;

    localparam logic [1:0] FAULT_OK       = 2'b00;
    localparam logic [1:0] FAULT_MISALIGN = 2'b01;
    localparam logic [1:0] FAULT_RANGE    = 2'b10;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [1:0]  fault;
    } imem_rsp_t;

endpackage

// File: rtl/rv_dpram.sv
// Simple dual-port RAM: port A byte-strobed write, port B registered read.
module rv_dpram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH),
    localparam int NB = WIDTH / 8
) (
    input  logic             clk,
    input  logic             wena,
    input  logic [AW-1:0]    addra,
    input  logic [WIDTH-1:0] dina,
    input  logic [NB-1:0]    strba,
    input  logic             renb,
    input  logic [AW-1:0]    addrb,
    output logic [WIDTH-1:0] doutb
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Both ports live in one block so a same-word read sees the old word.
    always_ff @(posedge clk) begin
        if (wena) begin
            for (int i = 0; i < NB; i++) begin
                if (strba[i]) begin
                    mem[addra][8*i +: 8] <= dina[8*i +: 8];
                end
            end
        end
        if (renb) begin
            doutb <= mem[addrb];
        end
    end

endmodule

// File: rtl/rv_imem_fetch.sv
// Instruction memory with valid/ready fetch port and 2-entry response buffer.
module rv_imem_fetch
    import rv_imem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int          AW        = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [63:0]   req_pc_i,
    input  logic          flush_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [31:0]   rsp_instr_o,
    output logic [63:0]   rsp_pc_o,
    output logic [1:0]    rsp_fault_o,
    input  logic          ld_en_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_data_i,
    input  logic [3:0]    ld_strb_i
);

    localparam logic [63:0] SPAN = 64'(DEPTH) << 2;

    logic [63:0] off;
    logic [1:0]  req_fault;
    logic        accept;
    logic        pop;
    logic [1:0]  occ;
    logic [31:0] rd_data;

    logic        infl_q;
    logic [63:0] infl_pc_q;
    logic [1:0]  infl_fault_q;
    imem_rsp_t   rbuf_q [2];
    logic [1:0]  cnt_q;

    imem_rsp_t   infl_ent;
    imem_rsp_t   head;
    imem_rsp_t   l0, l1;
    imem_rsp_t   nxt [2];
    logic [1:0]  nxt_cnt;

    assign off = req_pc_i - BASE_ADDR;

    always_comb begin
        req_fault = FAULT_OK;
        if (req_pc_i[1:0] != 2'b00) begin
            req_fault = FAULT_MISALIGN;
        end else if (off >= SPAN) begin
            req_fault = FAULT_RANGE;
        end
    end

    assign occ         = cnt_q + {1'b0, infl_q};
    assign req_ready_o = ~flush_i & (occ < 2'd2);
    assign accept      = req_valid_i & req_ready_o;
    assign rsp_valid_o = (cnt_q != 2'd0) | infl_q;
    assign pop         = rsp_valid_o & rsp_ready_i;

    rv_dpram #(
        .WIDTH(32),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .wena (ld_en_i),
        .addra(ld_addr_i),
        .dina (ld_data_i),
        .strba(ld_strb_i),
        .renb (accept),
        .addrb(off[AW+1:2]),
        .doutb(rd_data)
    );

    // The in-flight word is the youngest entry; faulted fetches show a NOP.
    always_comb begin
        infl_ent.instr = (infl_fault_q == FAULT_OK) ? rd_data : RV_NOP;
        infl_ent.pc    = infl_pc_q;
        infl_ent.fault = infl_fault_q;
    end

    assign head = (cnt_q == 2'd0 && infl_q) ? infl_ent : rbuf_q[0];
    assign rsp_instr_o = head.instr;
    assign rsp_pc_o    = head.pc;
    assign rsp_fault_o = head.fault;

    always_comb begin
        l0 = (cnt_q != 2'd0) ? rbuf_q[0] : infl_ent;
        l1 = (cnt_q == 2'd2) ? rbuf_q[1] : infl_ent;
        if (pop) begin
            nxt[0]  = l1;
            nxt[1]  = infl_ent;
            nxt_cnt = occ - 2'd1;
        end else begin
            nxt[0]  = l0;
            nxt[1]  = l1;
            nxt_cnt = occ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= 2'd0;
            infl_q       <= 1'b0;
            infl_pc_q    <= 64'h0;
            infl_fault_q <= FAULT_OK;
            rbuf_q[0]    <= '0;
            rbuf_q[1]    <= '0;
        end else if (flush_i) begin
            cnt_q  <= 2'd0;
            infl_q <= 1'b0;
        end else begin
            cnt_q  <= nxt_cnt;
            infl_q <= accept;
            if (accept) begin
                infl_pc_q    <= req_pc_i;
                infl_fault_q <= req_fault;
            end
            for (int i = 0; i < 2; i++) begin
                if (2'(i) < nxt_cnt) begin
                    rbuf_q[i] <= nxt[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv_imem_fetch.sv
// Bench for rv_imem_fetch: directed scenarios plus random traffic vs a queue model.
module tb_rv_imem_fetch;

    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [63:0] BASE  = 64'h0;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [63:0]   req_pc_i;
    logic          flush_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_instr_o;
    logic [63:0]   rsp_pc_o;
    logic [1:0]    rsp_fault_o;
    logic          ld_en_i;
    logic [AW-1:0] ld_addr_i;
    logic [31:0]   ld_data_i;
    logic [3:0]    ld_strb_i;

    always #5 clk = ~clk;

    rv_imem_fetch #(
        .DEPTH(DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_pc_i   (req_pc_i),
        .flush_i    (flush_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_instr_o(rsp_instr_o),
        .rsp_pc_o   (rsp_pc_o),
        .rsp_fault_o(rsp_fault_o),
        .ld_en_i    (ld_en_i),
        .ld_addr_i  (ld_addr_i),
        .ld_data_i  (ld_data_i),
        .ld_strb_i  (ld_strb_i)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [1:0]  fault;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [DEPTH];
    int          n_vec = 0;
    int          n_err = 0;
    bit          after_rst = 0;
    bit          last_acc = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit v, input logic [63:0] pc,
                       input bit rr, input bit fl);
        req_valid_i = v;
        req_pc_i    = pc;
        rsp_ready_i = rr;
        flush_i     = fl;
        ld_en_i     = 1'b0;
    endtask

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle(input bit do_chk);
        exp_t        e;
        bit          acc, pop;
        logic [63:0] off;
        #1;
        if (do_chk) begin
            chk("req_ready", 64'(req_ready_o),
                64'(!flush_i && q.size() < 2));
            chk("rsp_valid", 64'(rsp_valid_o), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("rsp_instr", 64'(rsp_instr_o), 64'(q[0].instr));
                chk("rsp_pc", rsp_pc_o, q[0].pc);
                chk("rsp_fault", 64'(rsp_fault_o), 64'(q[0].fault));
            end else if (after_rst) begin
                chk("rst_instr", 64'(rsp_instr_o), 64'h0);
                chk("rst_pc", rsp_pc_o, 64'h0);
                chk("rst_fault", 64'(rsp_fault_o), 64'h0);
            end
        end
        acc = req_valid_i && !flush_i && q.size() < 2;
        pop = rsp_ready_i && q.size() != 0;
        off = req_pc_i - BASE;
        e.pc = req_pc_i;
        if (req_pc_i[1:0] != 2'b00) e.fault = 2'b01;
        else if (off >= 64'(DEPTH * 4)) e.fault = 2'b10;
        else e.fault = 2'b00;
        e.instr = (e.fault != 2'b00) ? NOP : mem_m[off[AW+1:2]];
        @(posedge clk);
        after_rst = rst;
        last_acc  = 0;
        if (rst) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (flush_i) q.delete();
            else if (acc) begin
                q.push_back(e);
                last_acc = 1;
            end
        end
        if (ld_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (ld_strb_i[b]) mem_m[ld_addr_i][8*b +: 8] = ld_data_i[8*b +: 8];
            end
        end
        @(negedge clk);
    endtask

    task automatic load(input int a, input logic [31:0] d, input logic [3:0] s);
        ld_en_i   = 1'b1;
        ld_addr_i = AW'(a);
        ld_data_i = d;
        ld_strb_i = s;
    endtask

    initial begin
        logic [63:0] p;
        int          r;
        rst = 1'b1;
        drv(0, 64'h0, 0, 0);
        ld_addr_i = '0;
        ld_data_i = '0;
        ld_strb_i = '0;
        @(negedge clk);
        cycle(0);
        cycle(1);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            drv(0, 64'h0, 1, 0);
            load(i, (i < 3) ? 32'h11 * (i + 1) : $urandom, 4'hf);
            cycle(1);
        end

        // back-to-back fetches with consumer ready
        for (int i = 0; i < 3; i++) begin
            drv(1, 64'(4 * i), 1, 0);
            cycle(1);
        end
        drv(0, 64'h0, 1, 0);
        chk("t1_last_instr", 64'(rsp_instr_o), 64'h33);
        cycle(1);
        cycle(1);

        // back-pressure: exactly two accepts then ready drops
        p = 64'h0;
        for (int i = 0; i < 5; i++) begin
            drv(1, p, 0, 0);
            cycle(1);
            if (last_acc) p += 4;
        end
        chk("t2_stall_ready", 64'(req_ready_o), 64'h0);
        for (int i = 0; i < 3; i++) begin
            drv(0, 64'h0, 1, 0);
            cycle(1);
        end

        // faults
        drv(1, 64'h2, 1, 0);
        cycle(1);
        drv(1, 64'(DEPTH * 4), 1, 0);
        cycle(1);
        drv(0, 64'h0, 1, 0);
        chk("t3_range_fault", 64'(rsp_fault_o), 64'h2);
        cycle(1);
        cycle(1);

        // flush with a full buffer
        drv(1, 64'h0, 0, 0);
        cycle(1);
        drv(1, 64'h4, 0, 0);
        cycle(1);
        drv(1, 64'h0, 0, 1);
        cycle(1);
        drv(1, 64'h8, 1, 0);
        chk("t4_flushed", 64'(rsp_valid_o), 64'h0);
        cycle(1);
        drv(0, 64'h0, 1, 0);
        cycle(1);
        cycle(1);

        // read-during-write returns the old word
        load(5, 32'h1234_5678, 4'hf);
        cycle(1);
        drv(1, 64'h14, 1, 0);
        load(5, 32'hAABB_CCDD, 4'b0011);
        cycle(1);
        drv(1, 64'h14, 1, 0);
        chk("t5_old_word", 64'(rsp_instr_o), 64'h1234_5678);
        cycle(1);
        drv(0, 64'h0, 1, 0);
        chk("t5_new_word", 64'(rsp_instr_o), 64'h1234_CCDD);
        cycle(1);
        cycle(1);

        // reset with two entries pending
        drv(1, 64'h0, 0, 0);
        cycle(1);
        drv(1, 64'h4, 0, 0);
        cycle(1);
        rst = 1'b1;
        drv(1, 64'h8, 0, 0);
        cycle(1);
        rst = 1'b0;
        drv(0, 64'h0, 1, 0);
        chk("t6_rst_valid", 64'(rsp_valid_o), 64'h0);
        for (int i = 0; i < 3; i++) cycle(1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 15));
            if (r < 10) p = 64'(4 * $urandom_range(0, DEPTH - 1));
            else if (r < 12) p = 64'($urandom_range(0, 4 * DEPTH - 1));
            else if (r < 14) p = 64'(4 * $urandom_range(DEPTH, 4 * DEPTH));
            else p = {$urandom, $urandom} & ~64'h3;
            drv($urandom_range(0, 3) != 0, p, $urandom_range(0, 2) != 0,
                $urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                load(int'($urandom_range(0, DEPTH - 1)), $urandom,
                     4'($urandom_range(0, 15)));
            end
            rst = ($urandom_range(0, 63) == 0);
            cycle(1);
        end
        rst = 1'b0;
        drv(0, 64'h0, 1, 0);
        for (int i = 0; i < 4; i++) cycle(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
